sym_rx: RTL and testbench
=========================

SYM_RX -- requirements
Module: sym_rx

Interface
Parameters:
REQ-001 The block SHALL take parameter SYM_W, default 3: symbol width in bits.
REQ-002 The block SHALL take parameter SYMS_PER_WORD, default 3: symbols packed per output word.
REQ-003 The block SHALL take parameter DEPTH, default 4: output FIFO depth in words, power of two.

Ports:
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port a, input, SYM_W bits: symbol from the transmitter.
REQ-007 The block SHALL have port a_valid, input, 1 bit: symbol on a is valid this cycle.
REQ-008 The block SHALL have port a_ready, output, 1 bit: receiver accepts the symbol this cycle.
REQ-009 The block SHALL have port flush, input, 1 bit: discard the partial word held in the packer.
REQ-010 The block SHALL have port word, output, SYM_W*SYMS_PER_WORD bits: FIFO head word.
REQ-011 The block SHALL have port word_valid, output, 1 bit: word holds valid data.
REQ-012 The block SHALL have port word_ready, input, 1 bit: downstream consumes word.
REQ-013 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-014 A symbol SHALL be accepted in any cycle where a_valid && a_ready.
REQ-015 The packer SHALL be a state machine with states S0..S(SYMS_PER_WORD-1) (symbols held); an accepted symbol advances it one state, and S(last) wraps to S0.
REQ-016 Symbol k of a word (k=0 first) SHALL occupy bits [k*SYM_W +: SYM_W], LSB-first.
REQ-017 Acceptance in state S(last) SHALL push the completed word into the FIFO in the same edge.
REQ-018 a_ready SHALL be computed from registered state only, with no path from word_ready: 1 unless (state==S(last) && level==DEPTH).
REQ-019 word_valid SHALL equal (level != 0), and word SHALL be the FIFO head; a pop occurs when word_valid && word_ready.
REQ-020 Latency: a word completed at edge N SHALL be visible with word_valid=1 after edge N if the FIFO was empty (1 cycle).
REQ-021 Simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-022 Push is impossible when level==DEPTH; a pop in that cycle SHALL NOT enable a same-cycle push.
REQ-023 word, word_valid and level SHALL be stable while word_valid && !word_ready.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH.
REQ-025 flush=1 SHALL return the packer to S0 and drop held symbols; the FIFO is untouched.
REQ-026 A symbol presented with flush=1 in the same cycle SHALL be discarded and a_ready SHALL still follow REQ-018.
REQ-027 The block SHALL raise no error on a_valid=0; the packer simply holds its state.

Reset
REQ-028 rst_n=0 at a posedge SHALL set the packer to S0, level=0, pointers=0, word_valid=0 and word=0, overriding flush and all handshakes.
REQ-029 Reset mid-word or with a non-empty FIFO SHALL discard all held data, and a_ready SHALL be 1 from the first cycle after reset.

Structure
REQ-030 Package sym_pkg SHALL hold the SYM_W and SYMS_PER_WORD defaults, the word typedef and the packer-state enum.
REQ-031 The FIFO SHALL be sub-module sym_fifo (push, pop, din, dout, level); the packer FSM stays in sym_rx.

Verification
REQ-032 The bench SHALL check that symbols 3'b001, 3'b010, 3'b011 with word_ready=1 give word=9'b011_010_001 with word_valid=1 one cycle after the third accept.
REQ-033 The bench SHALL check that 15 symbols with word_ready=0 leave level=4 and the packer in S2 with a_ready=0; then word_ready=1 drains 4 words in order and a_ready returns to 1 after the first pop.
REQ-034 The bench SHALL check that after 2 symbols (7, 7), then flush=1 with a=5, then 1, 2, 3, the word is 9'b011_010_001 (the 7s and the 5 are dropped).
REQ-035 The bench SHALL check that with level=2 and continuous push plus pop, level stays at 2 for 10 cycles and words emerge in push order across pointer wrap.
REQ-036 The bench SHALL check that rst_n=0 with level=3 and the packer in S1 gives level=0, word_valid=0 and a_ready=1 the next cycle, and that the next 3 symbols form a clean word.
REQ-037 The bench SHALL check that a_valid is toggled randomly with word_ready held at 1 for 300 cycles, with the scoreboard showing no loss or reorder.

Source files
------------

// File: rtl/sym_pkg.sv
// sym_pkg: shared definitions for the symbol receiver.
//   SYM_W_DEF / SYMS_PER_WORD_DEF : default symbol width and symbols per word
//   word_t                        : packed output word at the default sizes
//   pk_state_t                    : packer state (number of symbols held)
package sym_pkg;

  localparam int SYM_W_DEF         = 3;
  localparam int SYMS_PER_WORD_DEF = 3;
  localparam int WORD_W_DEF        = SYM_W_DEF * SYMS_PER_WORD_DEF;

  typedef logic [WORD_W_DEF-1:0] word_t;

  // The encoding is wide enough for up to four symbols per word. Only the
  // states of the default word size are named.
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } pk_state_t;

endpackage

// File: rtl/sym_fifo.sv
// sym_fifo: word FIFO holding packed words for the downstream consumer.
//   clk, rst_n : clock and synchronous active-low reset
//   push, din  : write request and word to store (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head word, forced to zero while empty
//   level      : occupancy, 0..DEPTH
module sym_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty gating uses the registered level, so a pop never frees space
  // for a push in the same cycle.
  assign push_ok = push && (level_q != LVL_W'(DEPTH));
  assign pop_ok  = pop  && (level_q != '0);

  // Pointers are exactly log2(DEPTH) bits, so they wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = (level_q != '0) ? mem[rd_ptr] : '0;
  assign level = level_q;

endmodule

// File: rtl/sym_rx.sv
// sym_rx: packs SYM_W-bit symbols LSB-first into words of SYMS_PER_WORD
// symbols and queues the words in a DEPTH-entry FIFO.
//   clk, rst_n         : clock and synchronous active-low reset
//   a, a_valid, a_ready: symbol input handshake
//   flush              : drop the partially packed word
//   word, word_valid   : FIFO head and its valid flag
//   word_ready         : downstream consumes the head word
//   level              : FIFO occupancy
module sym_rx
  import sym_pkg::*;
#(
  parameter int SYM_W         = SYM_W_DEF,
  parameter int SYMS_PER_WORD = SYMS_PER_WORD_DEF,
  parameter int DEPTH         = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SYM_W-1:0]               a,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic                           flush,
  output logic [SYM_W*SYMS_PER_WORD-1:0] word,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic [$clog2(DEPTH):0]         level
);

  localparam int        WORD_W  = SYM_W * SYMS_PER_WORD;
  localparam int        LVL_W   = $clog2(DEPTH) + 1;
  localparam pk_state_t ST_LAST = pk_state_t'(ST_W'(SYMS_PER_WORD - 1));

  pk_state_t         state_q;
  pk_state_t         state_d;
  logic [WORD_W-1:0] hold_p0;
  logic [WORD_W-1:0] push_word;
  logic              full;
  logic              accept;
  logic              push;

  // Back-pressure only when the incoming symbol would complete a word with
  // nowhere to put it; depends on registered state only.
  assign full    = (level == LVL_W'(DEPTH));
  assign a_ready = !((state_q == ST_LAST) && full);
  assign accept  = a_valid && a_ready && !flush;
  assign push    = accept && (state_q == ST_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S0;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S0;
    end else if (accept) begin
      if (state_q == ST_LAST) state_d = S0;
      else                    state_d = pk_state_t'(state_q + ST_W'(1));
    end
  end

  // ---- stage p0: symbol holding register (slot index = packer state) ----
  always_ff @(posedge clk) begin
    if (accept) hold_p0[int'(state_q)*SYM_W +: SYM_W] <= a;
  end

  // The completing symbol bypasses the holding register so the word enters
  // the FIFO on the same edge it is accepted.
  always_comb begin
    push_word = hold_p0;
    push_word[(SYMS_PER_WORD-1)*SYM_W +: SYM_W] = a;
  end

  // ---- stage p1: output FIFO ----
  sym_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (word_ready),
    .din   (push_word),
    .dout  (word),
    .level (level)
  );

  assign word_valid = (level != '0);

endmodule

// File: tb/tb_sym_rx.sv
// tb_sym_rx: directed self-checking bench for sym_rx at default parameters.
module tb_sym_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] a;
  logic       a_valid;
  logic       a_ready;
  logic       flush;
  logic [8:0] word;
  logic       word_valid;
  logic       word_ready;
  logic [2:0] level;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  int         m_cnt;
  logic [8:0] m_word;

  sym_rx #(.SYM_W(3), .SYMS_PER_WORD(3), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .flush      (flush),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .level      (level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] pk(input logic [2:0] s0, input logic [2:0] s1,
                                    input logic [2:0] s2);
    return {s2, s1, s0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_valid = 1'b0; flush = 1'b0; word_ready = 1'b0; a = '0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    m_cnt  = 0;
    m_word = '0;
  endtask

  task automatic send(input logic [2:0] sym);
    int n;
    n = 0;
    a = sym;
    a_valid = 1'b1;
    while (!a_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("send_ready", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
  endtask

  // One clock of scoreboard-driven traffic: check the head against the model,
  // update the packer model on an accept, then advance.
  task automatic cycle(input logic av, input logic [2:0] sym, input logic wr);
    a_valid = av; a = sym; word_ready = wr;
    chk("wv_model", 32'(word_valid), 32'(exp_q.size() != 0));
    if (word_valid && wr && exp_q.size() != 0) chk("word_order", 32'(word), 32'(exp_q.pop_front()));
    if (av && a_ready) begin
      m_word[m_cnt*3 +: 3] = sym;
      if (m_cnt == 2) begin
        exp_q.push_back(m_word);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    step();
  endtask

  initial begin
    logic [2:0] s;
    rst_n = 1'b1; a_valid = 1'b0; flush = 1'b0; word_ready = 1'b0; a = '0;

    // Basic packing and latency
    do_reset();
    chk("rst_wv", 32'(word_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ardy", 32'(a_ready), 32'd1);
    chk("rst_word", 32'(word), 32'd0);
    word_ready = 1'b1;
    send(3'd1); send(3'd2); send(3'd3);
    chk("basic_wv", 32'(word_valid), 32'd1);
    chk("basic_word", 32'(word), 32'h0D1);
    step();
    chk("basic_popped_wv", 32'(word_valid), 32'd0);
    chk("basic_popped_word", 32'(word), 32'd0);

    // Fill to full with the packer in the last state, then drain
    do_reset();
    for (int i = 0; i < 14; i++) send(3'(i + 1));
    chk("full_level", 32'(level), 32'd4);
    chk("full_state", 32'(dut.state_q), 32'd2);
    chk("full_ardy", 32'(a_ready), 32'd0);
    a = 3'd5; a_valid = 1'b1;
    chk("full_ardy_valid", 32'(a_ready), 32'd0);
    step();
    chk("full_hold_level", 32'(level), 32'd4);
    chk("full_hold_state", 32'(dut.state_q), 32'd2);
    a_valid = 1'b0;
    word_ready = 1'b1;
    chk("drain_w0", 32'(word), 32'(pk(3'd1, 3'd2, 3'd3)));
    step();
    chk("drain_ardy", 32'(a_ready), 32'd1);
    chk("drain_level", 32'(level), 32'd3);
    chk("drain_w1", 32'(word), 32'(pk(3'd4, 3'd5, 3'd6)));
    step();
    chk("drain_w2", 32'(word), 32'(pk(3'd7, 3'd0, 3'd1)));
    step();
    chk("drain_w3", 32'(word), 32'(pk(3'd2, 3'd3, 3'd4)));
    step();
    chk("drain_empty_level", 32'(level), 32'd0);
    chk("drain_empty_wv", 32'(word_valid), 32'd0);

    // Flush drops held symbols and the symbol presented with it
    do_reset();
    send(3'd7); send(3'd7);
    a = 3'd5; a_valid = 1'b1; flush = 1'b1;
    chk("flush_ardy", 32'(a_ready), 32'd1);
    step();
    flush = 1'b0; a_valid = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_state", 32'(dut.state_q), 32'd0);
    send(3'd1); send(3'd2); send(3'd3);
    chk("flush_word_level", 32'(level), 32'd1);
    chk("flush_word", 32'(word), 32'h0D1);

    // Steady level 2 with push and pop on the same edge, across pointer wrap
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 3'(i * 5 + 2), 1'b0);
    chk("steady_fill_level", 32'(level), 32'd2);
    for (int i = 0; i < 30; i++) begin
      s = 3'(i * 3 + 1);
      cycle(1'b1, s, 1'(m_cnt == 2));
      chk("steady_level", 32'(level), 32'd2);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 1'b1);
    chk("steady_drained_level", 32'(level), 32'd0);
    chk("steady_model_empty", 32'(exp_q.size()), 32'd0);

    // Reset with a non-empty FIFO and a partial word
    do_reset();
    for (int i = 0; i < 10; i++) send(3'(i));
    chk("prerst_level", 32'(level), 32'd3);
    chk("prerst_state", 32'(dut.state_q), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_wv", 32'(word_valid), 32'd0);
    chk("midrst_ardy", 32'(a_ready), 32'd1);
    chk("midrst_word", 32'(word), 32'd0);
    send(3'd4); send(3'd5); send(3'd6);
    chk("postrst_level", 32'(level), 32'd1);
    chk("postrst_word", 32'(word), 32'(pk(3'd4, 3'd5, 3'd6)));

    // Random a_valid with word_ready held high
    do_reset();
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 1'b1);
    chk("rand_model_empty", 32'(exp_q.size()), 32'd0);
    chk("rand_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
